// File: rtl/radix4_booth_wallace32.sv
// 32x32->64 signed/unsigned multiplier: radix-4 Booth rows, 3:2 carry-save Wallace tree, one final adder.
// Latency 1 cycle (2 cycles when BOOTH_INPUT_REG_EN is defined); a new operand pair every cycle.
// No backpressure: no handshake, never stalls, out is registered.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset, clears every flop (out = 0 while held)
//   signedFlag   1 = two's-complement operands, 0 = unsigned; travels with its operand pair
//   multiplicand operand X
//   multiplier   operand Y
//   out          registered 64-bit product X*Y
//
// Build option: define BOOTH_INPUT_REG_EN to register the operands and signedFlag
// ahead of the Booth encoder (adds one cycle of latency, same arithmetic).

module radix4_booth_wallace32 #(
  parameter int M = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           signedFlag,
  input  logic [M-1:0]   multiplicand,
  input  logic [M-1:0]   multiplier,
  output logic [2*M-1:0] out
);

  localparam int PP    = (M + 2) / 2;  // Booth rows
  localparam int XW    = M + 2;        // extended operand width
  localparam int PW    = M + 3;        // width of +/-2X
  localparam int OW    = 2 * M;        // product width
  localparam int NROWS = PP + 2;       // Booth rows + negate-bit row + sign constant row

  // Rows left after applying l levels of 3:2 compression to n rows.
  function automatic int rows_after(input int n, input int l);
    int c;
    c = n;
    for (int k = 0; k < l; k++) c = c - c / 3;
    return c;
  endfunction

  function automatic int levels_for(input int n);
    int c;
    int lv_cnt;
    c = n;
    lv_cnt = 0;
    while (c > 2) begin
      c = c - c / 3;
      lv_cnt = lv_cnt + 1;
    end
    return lv_cnt;
  endfunction

  // Each row's sign extension is replaced by its inverted sign bit at weight
  // 2^(XW+2i); this constant subtracts the 2^(XW+2i) terms that trick introduces.
  function automatic logic [OW-1:0] sext_const();
    logic [OW-1:0] k;
    k = '0;
    for (int i = 0; i < PP; i++) begin
      if (XW + 2 * i < OW) k = k + (OW'(1) << (XW + 2 * i));
    end
    return ~k + OW'(1);
  endfunction

  localparam int              LEVELS = levels_for(NROWS);
  localparam logic [OW-1:0]   K_SEXT = sext_const();

  // ---------------------------------------------------------------- operand stage
  logic [M-1:0] x_op;
  logic [M-1:0] y_op;
  logic         sgn_op;

`ifdef BOOTH_INPUT_REG_EN
  logic [M-1:0] x_q;
  logic [M-1:0] y_q;
  logic         sgn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      sgn_q <= 1'b0;
    end else begin
      x_q   <= multiplicand;
      y_q   <= multiplier;
      sgn_q <= signedFlag;
    end
  end

  assign x_op   = x_q;
  assign y_op   = y_q;
  assign sgn_op = sgn_q;
`else
  assign x_op   = multiplicand;
  assign y_op   = multiplier;
  assign sgn_op = signedFlag;
`endif

  // ---------------------------------------------------------------- Booth rows
  logic [XW-1:0] xe;
  logic [XW:0]   yb;       // extended Y with the implicit y[-1]=0 appended at the bottom
  logic [OW-1:0] neg_bits;
  logic [OW-1:0] lv [LEVELS+1][NROWS];

  assign xe = sgn_op ? {{2{x_op[M-1]}}, x_op} : {2'b00, x_op};
  assign yb = sgn_op ? {{2{y_op[M-1]}}, y_op, 1'b0} : {2'b00, y_op, 1'b0};

  for (genvar i = 0; i < PP; i++) begin : g_pp
    logic [2:0]    trip;
    logic          one;
    logic          two;
    logic          neg;
    logic [PW-1:0] mag;
    logic [PW-1:0] sel;

    assign trip = yb[2*i+2 -: 3];
    assign neg  = trip[2];
    assign one  = trip[1] ^ trip[0];
    assign two  = (trip == 3'b011) || (trip == 3'b100);
    assign mag  = one ? {xe[XW-1], xe} : (two ? {xe, 1'b0} : '0);
    // One's complement here; the +1 completing the negation rides in neg_bits.
    assign sel  = neg ? ~mag : mag;

    assign lv[0][i] = OW'({~sel[PW-1], sel[PW-2:0]}) << (2 * i);

    assign neg_bits[2*i]   = neg;
    assign neg_bits[2*i+1] = 1'b0;
  end

  assign neg_bits[OW-1:2*PP] = '0;
  assign lv[0][PP]           = neg_bits;
  assign lv[0][PP+1]         = K_SEXT;

  // ---------------------------------------------------------------- Wallace tree
  // Each level groups rows in threes through word-wide full adders; leftover
  // rows pass straight down. Unused slots are tied to zero.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NI = rows_after(NROWS, l);
    localparam int NG = NI / 3;
    localparam int NO = NI - NG;

    for (genvar g = 0; g < NG; g++) begin : g_csa
      assign lv[l+1][2*g]   = lv[l][3*g] ^ lv[l][3*g+1] ^ lv[l][3*g+2];
      assign lv[l+1][2*g+1] = ((lv[l][3*g]   & lv[l][3*g+1]) |
                               (lv[l][3*g]   & lv[l][3*g+2]) |
                               (lv[l][3*g+1] & lv[l][3*g+2])) << 1;
    end

    for (genvar k = 0; k < NI - 3 * NG; k++) begin : g_pass
      assign lv[l+1][2*NG+k] = lv[l][3*NG+k];
    end

    for (genvar z = NO; z < NROWS; z++) begin : g_zero
      assign lv[l+1][z] = '0;
    end
  end

  for (genvar z = NROWS; z < NROWS; z++) begin : g_unused
  end

  // ---------------------------------------------------------------- final adder + output register
  logic [OW-1:0] prod_d;
  logic [OW-1:0] prod_q;

  assign prod_d = lv[LEVELS][0] + lv[LEVELS][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prod_q <= '0;
    else     prod_q <= prod_d;
  end

  assign out = prod_q;

endmodule

// File: tb/tb_radix4_booth_wallace32.sv
// Scoreboard bench for radix4_booth_wallace32: random, swept and corner operand pairs against an arithmetic model.
// Expected results queue at issue time; a monitor pops one per cycle once the pipeline latency has elapsed.
// DUT has no backpressure; the bench issues at most one pair per cycle and tracks validity itself.

module tb_radix4_booth_wallace32;

`ifdef BOOTH_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signedFlag = 1'b0;
  logic [31:0] multiplicand = 32'hFFFF_FFFF;
  logic [31:0] multiplier = 32'hFFFF_FFFF;
  logic [63:0] out;

  always #5 clk = ~clk;

  radix4_booth_wallace32 dut (
    .clk          (clk),
    .rst          (rst),
    .signedFlag   (signedFlag),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out          (out)
  );

  logic [63:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        drv_vld = 1'b0;
  logic [1:0]  vpipe;

  // Tracks which cycles carry a real result at the output.
  always @(posedge clk or posedge rst) begin
    if (rst) vpipe <= 2'b00;
    else     vpipe <= {vpipe[0], drv_vld};
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint a;
    longint b;
    if (s) begin
      a = longint'($signed(x));
      b = longint'($signed(y));
    end else begin
      a = longint'({32'h0, x});
      b = longint'({32'h0, y});
    end
    return 64'(a * b);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: out=%h expected=%h", name, got, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && vpipe[LAT-1]) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: out=%h expected=<none queued>", out);
      end else begin
        check("pipe", out, exp_q.pop_front());
      end
    end
  end

  task automatic apply(input logic [31:0] x, input logic [31:0] y, input logic s);
    @(negedge clk);
    multiplicand = x;
    multiplier   = y;
    signedFlag   = s;
    drv_vld      = 1'b1;
    exp_q.push_back(ref_mul(x, y, s));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drv_vld = 1'b0;
    end
  endtask

  task automatic sweep(input logic s);
    logic [31:0] vals [$];
    for (longint v = 0; v <= 64'hFFFF_FFFF; v += 64'h03FF_FFFF) vals.push_back(32'(v));
    if (vals[vals.size()-1] != 32'hFFFF_FFFF) vals.push_back(32'hFFFF_FFFF);
    foreach (vals[i]) foreach (vals[j]) apply(vals[i], vals[j], s);
  endtask

  initial begin
    // Reset held with all-ones operands: output must stay zero.
    repeat (3) @(negedge clk);
    check("reset_hold", out, 64'h0);

    // Release: the pair present at the first edge is the first result.
    @(negedge clk);
    rst        = 1'b0;
    signedFlag = 1'b0;
    drv_vld    = 1'b1;
    exp_q.push_back(64'hFFFF_FFFE_0000_0001);

    // Corners and zero/all-ones boundaries.
    apply(32'h8000_0000, 32'h8000_0000, 1'b1);
    apply(32'h8000_0000, 32'h0000_0001, 1'b1);
    apply(32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    apply(32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    apply(32'h0000_0000, 32'hDEAD_BEEF, 1'b1);
    apply(32'h8000_0001, 32'h0000_0000, 1'b0);
    idle(2);

    sweep(1'b0);
    sweep(1'b1);

    // Back-to-back random pairs with signedness alternating each cycle.
    for (int k = 0; k < 300; k++) apply($urandom(), $urandom(), k[0]);
    idle(LAT + 2);

    // Reset in the middle of traffic: in-flight results must vanish.
    for (int k = 0; k < 4; k++) apply($urandom(), $urandom(), k[0]);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk);
    #2;
    rst     = 1'b1;
    drv_vld = 1'b0;
    #1;
    check("async_reset", out, 64'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("reset_held", out, 64'h0);

    @(negedge clk);
    rst          = 1'b0;
    multiplicand = 32'hFFFF_FFFF;
    multiplier   = 32'hFFFF_FFFF;
    signedFlag   = 1'b0;
    drv_vld      = 1'b1;
    exp_q.push_back(64'hFFFF_FFFE_0000_0001);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    for (int k = 0; k < 20; k++) apply($urandom(), $urandom(), $urandom_range(0, 1) == 1);
    idle(LAT + 3);

    // Every issued pair must have produced a result.
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
